spi_master_burst: RTL and testbench
===================================

Name: spi_master_burst

Overview:
Parametrised SPI master, the successor to the fixed 24-bit SPI write/read master.
- Sends one frame per start: device-ID byte (SLAVE_ID, R/W bit), ADDR_W-bit address, then a burst of 1..2^LEN_W data words of DATA_W bits.
- Runtime-selectable SPI mode (CPOL/CPHA), clock divider and one-of-NUM_SS chip select.
- Full-duplex capture. Sits between the register/control logic and external SPI peripherals.

Parameters:
- DIV_W, 10, width of the divider input.
- DATA_W, 8, bits per data word (≥2).
- ADDR_W, 8, address field width (≥1).
- LEN_W, 4, burst length field width.
- NUM_SS, 2, number of slave-select lines.
- SLAVE_ID, 7'h32, 7-bit device ID. ID byte = {SLAVE_ID, rw}.

Ports:
- n_reset  in  1  Reset, asynchronous, active-low.
- clock  in  1  System clock; all logic on posedge.
- start  in  1  One-cycle request pulse. Ignored while busy.
- rw  in  1  0 = write, 1 = read.
- cpol  in  1  SCK idle level.
- cpha  in  1  0 = sample on leading edge, 1 = sample on trailing edge.
- div  in  DIV_W  Half-period of SCK = div+1 clocks.
- ss_sel  in  clog2(NUM_SS)  Slave index.
- addr  in  ADDR_W  Register address.
- len  in  LEN_W  Words in burst minus 1.
- wdata  in  DATA_W  Write word.
- wdata_req  out  1  Pulse: current wdata consumed; present next word.
- rdata  out  DATA_W  Last received word.
- rdata_valid  out  1  Pulse: rdata updated.
- busy  out  1  High from the cycle after start until the cycle done pulses.
- done  out  1  One-cycle pulse at frame end.
- ss_n  out  NUM_SS  Active-low slave selects.
- sck  out  1  SPI clock.
- mosi  out  1  Master out.
- miso  in  1  Master in.

Behaviour:
- Reset values: ss_n all 1, sck 0, mosi 0, rdata 0, rdata_valid 0, wdata_req 0, busy 0, done 0. State IDLE.
- Reset asserted mid-frame aborts immediately to these values. No done pulse.
- Latching: on start in IDLE, latch rw, cpol, cpha, div, ss_sel, addr, len and the first wdata. Pulse wdata_req the next cycle. sck is driven to cpol.
- Frame length N = 8 + ADDR_W + (len+1)*DATA_W bits, all MSB first.
- FSM states: IDLE, SETUP, SHIFT, HOLD, GAP.
- IDLE→SETUP on start.
  - ss_n[ss_sel] goes low in the first SETUP cycle.
  - If cpha=0, the ID MSB is driven on mosi.
- SETUP lasts div+1 clocks, then →SHIFT.
- SHIFT: a half-period counter toggles sck every div+1 clocks. Each bit spans two half-periods.
  - cpha=0: sample miso on the leading edge; drive the next bit on the trailing edge.
  - cpha=1: drive the bit on the leading edge; sample on the trailing edge.
- After the final trailing edge of bit N: →HOLD. sck stays at cpol.
- HOLD lasts div+1 clocks. Then ss_n goes all 1, done pulses and busy drops. →GAP.
- GAP lasts div+1 clocks with ss_n high, then →IDLE. busy is low during GAP, but start is ignored until IDLE.
- Write data: when a data word's first bit is loaded into the shift register, wdata is sampled.
  - wdata_req pulses one cycle after each word load, except after the last word.
  - Upstream must hold the new word stable from the pulse until the next load.
- Read data: mosi is driven 0 throughout the data phase when rw=1.
- Capture is full duplex: in both modes, miso bits of each data word shift in.
  - One clock after the word's last sample, rdata is updated and rdata_valid pulses.
  - ID and address phases produce no rdata_valid.
- Counters: the bit counter is wide enough for the max N. The half-period counter is DIV_W wide and compares to div. No wrap within a frame.
- div=0: sck toggles every clock (clock/2).
- start while busy or in GAP is dropped. It has no effect on the latched fields.
- ss_sel ≥ NUM_SS: frame runs but no ss_n line asserts.

Optional Feature:
SPI_LOOPBACK_EN.
- Defined: adds input port loopback (1 bit).
  - When loopback=1, the internal miso is mosi, sampled at the normal sample point.
  - External miso is ignored and ss_n stays all 1. sck still toggles.
- Undefined: no port; miso is always used.

Test Plan:
1. Write, cpol=0 cpha=0, div=4, ss_sel=1, addr=8'hA5, len=0, wdata=8'h3C.
   → ss_n=2'b01; mosi bits 0x64,0xA5,0x3C; sck high 5 clocks, low 5 clocks; 24 rising edges; done one pulse; no wdata_req after the single word.
2. Read, cpha=1 cpol=1, len=2; slave model returns 8'h11, 8'h22, 8'h33.
   → ID 0x65; mosi 0 in data phase; rdata_valid three times with rdata 11, 22, 33; sck idles high.
3. Burst write, len=3, wdata sourced from a FIFO on each wdata_req.
   → 3 wdata_req pulses; mosi carries words 0..3 in order; N=48.
4. div=0 and max div=1023.
   → sck period 2 and 2048 clocks; frame bit count unchanged.
5. start pulsed mid-frame, then n_reset asserted at bit 10.
   → second start ignored; on reset, ss_n=all 1, sck=0, busy=0, no done pulse.
6. SPI_LOOPBACK_EN defined, loopback=1, write len=1, wdata 8'h5A then 8'hC3.
   → rdata_valid with 5A, then C3; ss_n stays all 1.

Source files
------------

// File: rtl/spi_master_burst.sv
// Burst SPI master: ID byte {SLAVE_ID,rw}, address, 1..2^LEN_W data words, runtime CPOL/CPHA/divider.
// Optional SPI_LOOPBACK_EN adds a loopback input (miso := mosi, slave selects held high).
module spi_master_burst #(
   parameter int         DIV_W    = 10,
   parameter int         DATA_W   = 8,
   parameter int         ADDR_W   = 8,
   parameter int         LEN_W    = 4,
   parameter int         NUM_SS   = 2,
   parameter logic [6:0] SLAVE_ID = 7'h32,
   localparam int        SS_W     = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
   input  logic              n_reset,
   input  logic              clock,
   input  logic              start,
   input  logic              rw,
   input  logic              cpol,
   input  logic              cpha,
   input  logic [DIV_W-1:0]  div,
   input  logic [SS_W-1:0]   ss_sel,
   input  logic [ADDR_W-1:0] addr,
   input  logic [LEN_W-1:0]  len,
   input  logic [DATA_W-1:0] wdata,
   output logic              wdata_req,
   output logic [DATA_W-1:0] rdata,
   output logic              rdata_valid,
   output logic              busy,
   output logic              done,
   output logic [NUM_SS-1:0] ss_n,
   output logic              sck,
   output logic              mosi,
`ifdef SPI_LOOPBACK_EN
   input  logic              loopback,
`endif
   input  logic              miso
);

   localparam int HDR_W = 8 + ADDR_W;
   localparam int MAX_N = HDR_W + (2**LEN_W) * DATA_W;
   localparam int BC_W  = $clog2(MAX_N);
   localparam int WP_W  = $clog2(DATA_W);

   typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;
   state_t state_q, state_d;

   logic              rw_q, cpol_q, cpha_q;
   logic [DIV_W-1:0]  div_q, hcnt;
   logic [LEN_W-1:0]  len_q, widx;
   logic [DATA_W-1:0] wbuf_q, dat_sr, rx_sr, rdata_q;
   logic [HDR_W-1:0]  hdr_sr, hdr_init;
   logic [BC_W-1:0]   bcnt;
   logic [WP_W-1:0]   wpos;
   logic [NUM_SS-1:0] ss_q, ss_dec;
   logic              sck_q, mosi_q, cap_pend, rdata_valid_q, wdata_req_q, done_q;
   logic              miso_i;

   logic              hc_done, in_hdr, hdr_last, word_end, last_bit, lead;
   logic              sck_edge, samp, drive, advance;
   logic              d_hdr, d_first;
   logic [LEN_W-1:0]  d_widx, nxt_widx;
   logic [DATA_W-1:0] d_word;

`ifdef SPI_LOOPBACK_EN
   assign miso_i = loopback ? mosi_q : miso;
   assign ss_n   = ss_q | {NUM_SS{loopback}};
`else
   assign miso_i = miso;
   assign ss_n   = ss_q;
`endif

   assign sck         = sck_q;
   assign mosi        = mosi_q;
   assign rdata       = rdata_q;
   assign rdata_valid = rdata_valid_q;
   assign wdata_req   = wdata_req_q;
   assign done        = done_q;
   assign busy        = (state_q == SETUP) || (state_q == SHIFT) || (state_q == HOLD);
   assign hdr_init    = {SLAVE_ID, rw, addr};

   // Bit position bookkeeping: bcnt/wpos/widx describe the bit currently on the wire.
   assign hc_done  = (hcnt == div_q);
   assign in_hdr   = (bcnt < BC_W'(HDR_W));
   assign hdr_last = (bcnt == BC_W'(HDR_W - 1));
   assign word_end = (wpos == WP_W'(DATA_W - 1));
   assign last_bit = !in_hdr && word_end && (widx == len_q);
   assign lead     = (sck_q == cpol_q);
   assign sck_edge = (state_q == SHIFT) && hc_done;
   assign samp     = sck_edge && (lead != cpha_q);
   assign advance  = sck_edge && !lead && !last_bit;
   assign drive    = sck_edge && (cpha_q ? lead : (!lead && !last_bit));
   assign nxt_widx = hdr_last ? '0 : ((!in_hdr && word_end) ? widx + LEN_W'(1) : widx);

   // CPHA=1 drives the current bit on the leading edge; CPHA=0 drives the following bit on the trailing edge.
   assign d_hdr   = cpha_q ? in_hdr : (in_hdr && !hdr_last);
   assign d_first = cpha_q ? (!in_hdr && (wpos == '0)) : (hdr_last || (!in_hdr && word_end));
   assign d_widx  = cpha_q ? widx : nxt_widx;
   assign d_word  = (d_widx == '0) ? wbuf_q : wdata;

   always_comb begin
      ss_dec = '1;
      for (int i = 0; i < NUM_SS; i++) ss_dec[i] = (ss_sel != SS_W'(i));
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = SETUP;
         SETUP:   if (hc_done) state_d = SHIFT;
         SHIFT:   if (sck_edge && !lead && last_bit) state_d = HOLD;
         HOLD:    if (hc_done) state_d = GAP;
         GAP:     if (hc_done) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge n_reset) begin
      if (!n_reset) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_ff @(posedge clock or negedge n_reset) begin
      if (!n_reset) begin
         rw_q <= 1'b0; cpol_q <= 1'b0; cpha_q <= 1'b0;
         div_q <= '0; hcnt <= '0; len_q <= '0; widx <= '0;
         wbuf_q <= '0; dat_sr <= '0; rx_sr <= '0; rdata_q <= '0;
         hdr_sr <= '0; bcnt <= '0; wpos <= '0; ss_q <= '1;
         sck_q <= 1'b0; mosi_q <= 1'b0; cap_pend <= 1'b0;
         rdata_valid_q <= 1'b0; wdata_req_q <= 1'b0; done_q <= 1'b0;
      end else begin
         rdata_valid_q <= 1'b0;
         wdata_req_q   <= 1'b0;
         done_q        <= 1'b0;
         cap_pend      <= 1'b0;

         if (state_q == IDLE || hc_done) hcnt <= '0;
         else                            hcnt <= hcnt + DIV_W'(1);

         if (state_q == IDLE && start) begin
            rw_q <= rw; cpol_q <= cpol; cpha_q <= cpha;
            div_q <= div; len_q <= len; wbuf_q <= wdata;
            bcnt <= '0; wpos <= '0; widx <= '0;
            ss_q <= ss_dec;
            sck_q <= cpol;
            wdata_req_q <= (len != '0);
            mosi_q <= cpha ? 1'b0 : SLAVE_ID[6];
            hdr_sr <= cpha ? hdr_init : (hdr_init << 1);
         end

         if (drive) begin
            if (d_hdr) begin
               mosi_q <= hdr_sr[HDR_W-1];
               hdr_sr <= hdr_sr << 1;
            end else if (d_first) begin
               mosi_q      <= !rw_q && d_word[DATA_W-1];
               dat_sr      <= d_word << 1;
               wdata_req_q <= (d_widx != '0) && (d_widx != len_q);
            end else begin
               mosi_q <= !rw_q && dat_sr[DATA_W-1];
               dat_sr <= dat_sr << 1;
            end
         end

         if (sck_edge) sck_q <= ~sck_q;

         if (samp && !in_hdr) begin
            rx_sr    <= {rx_sr[DATA_W-2:0], miso_i};
            cap_pend <= word_end;
         end

         if (cap_pend) begin
            rdata_q       <= rx_sr;
            rdata_valid_q <= 1'b1;
         end

         if (advance) begin
            bcnt <= bcnt + BC_W'(1);
            wpos <= (in_hdr || word_end) ? '0 : wpos + WP_W'(1);
            widx <= nxt_widx;
         end

         if (state_q == HOLD && hc_done) begin
            ss_q   <= '1;
            done_q <= 1'b1;
            mosi_q <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_spi_master_burst.sv
// Directed bench for spi_master_burst: modes, bursts, divider extremes, abort, optional loopback.
module tb_spi_master_burst;

   logic       clock = 1'b0, n_reset = 1'b0, start = 1'b0, rw = 1'b0, cpol = 1'b0, cpha = 1'b0;
   logic [9:0] div = '0;
   logic [0:0] ss_sel = '0;
   logic [7:0] addr = '0, wdata = '0;
   logic [3:0] len = '0;
   logic       miso = 1'b0, loopback = 1'b0;
   logic       wdata_req, rdata_valid, busy, done, sck, mosi;
   logic [7:0] rdata;
   logic [1:0] ss_n;

   always #5 clock = ~clock;

   spi_master_burst dut (
      .n_reset(n_reset), .clock(clock), .start(start), .rw(rw), .cpol(cpol), .cpha(cpha),
      .div(div), .ss_sel(ss_sel), .addr(addr), .len(len), .wdata(wdata),
      .wdata_req(wdata_req), .rdata(rdata), .rdata_valid(rdata_valid), .busy(busy),
      .done(done), .ss_n(ss_n), .sck(sck), .mosi(mosi),
`ifdef SPI_LOOPBACK_EN
      .loopback(loopback),
`endif
      .miso(miso)
   );

   int nvec = 0, nmis = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nmis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   logic [7:0]  wlist [4];
   logic [7:0]  mlist [4];
   logic [7:0]  rd [4];
   logic [63:0] cap;
   logic [1:0]  ss_act, ss_end;
   logic        sck_end, busy_end, aborted;
   int          nlead, ntrail, nreq, ndone, nvalid, hp_min, hp_max;

   // Slave stream: 16 header bits of zero followed by the mlist words, MSB first.
   function automatic logic miso_bit(input int k);
      int j;
      if (k < 16) return 1'b0;
      j = k - 16;
      if (j >= 32) return 1'b0;
      return mlist[j / 8][7 - (j % 8)];
   endfunction

   task automatic run_frame(input logic f_rw, input logic f_cpol, input logic f_cpha,
                            input logic [9:0] f_div, input logic [0:0] f_sel,
                            input logic [7:0] f_addr, input logic [3:0] f_len,
                            input int mid_bit, input int abort_bit);
      int   budget, run, ptr, nbits;
      logic prev;
      nbits  = 16 + (int'(f_len) + 1) * 8;
      budget = (2 * nbits + 8) * (int'(f_div) + 1) + 20;
      cap = '0; nlead = 0; ntrail = 0; nreq = 0; ndone = 0; nvalid = 0;
      hp_min = 1 << 30; hp_max = 0; ss_act = 2'bxx; aborted = 1'b0;
      sck_end = 1'bx; ss_end = 2'bxx; busy_end = 1'bx;
      for (int i = 0; i < 4; i++) rd[i] = 8'hxx;
      @(negedge clock);
      rw = f_rw; cpol = f_cpol; cpha = f_cpha; div = f_div; ss_sel = f_sel;
      addr = f_addr; len = f_len; ptr = 0; wdata = wlist[0];
      miso = f_cpha ? 1'b0 : miso_bit(0);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      chk("busy_after_start", busy, 1'b1);
      chk("sck_idle_level", sck, f_cpol);
      prev = sck; run = 0;
      for (int c = 0; c < budget; c++) begin
         start = 1'b0;
         if (wdata_req) begin
            nreq++;
            if (ptr < 3) ptr++;
            wdata = wlist[ptr];
         end
         if (rdata_valid) begin
            if (nvalid < 4) rd[nvalid] = rdata;
            nvalid++;
         end
         if (sck !== prev) begin
            if (nlead + ntrail > 0) begin
               if (run + 1 < hp_min) hp_min = run + 1;
               if (run + 1 > hp_max) hp_max = run + 1;
            end
            run = 0;
            if (sck !== f_cpol) begin
               nlead++;
               if (nlead == 1) ss_act = ss_n;
               if (!f_cpha) cap = {cap[62:0], mosi};
               else         miso = miso_bit(nlead - 1);
               if (nlead == mid_bit) begin
                  start = 1'b1; rw = ~f_rw; cpol = ~f_cpol; ss_sel = ~f_sel; addr = ~f_addr;
               end
               if (nlead == abort_bit) begin
                  aborted = 1'b1;
                  break;
               end
            end else begin
               ntrail++;
               if (f_cpha) cap = {cap[62:0], mosi};
               else        miso = miso_bit(ntrail);
            end
         end else begin
            run++;
         end
         prev = sck;
         if (done) begin
            ndone++;
            sck_end = sck; ss_end = ss_n; busy_end = busy;
            break;
         end
         @(negedge clock);
      end
   endtask

   task automatic wait_gap(input int n);
      repeat (n) @(negedge clock);
   endtask

   initial begin
      int cnt_done, cnt_busy;
      repeat (3) @(negedge clock);
      chk("rst_ss_n", ss_n, 2'b11);
      chk("rst_sck", sck, 1'b0);
      chk("rst_mosi", mosi, 1'b0);
      chk("rst_rdata", rdata, 8'h00);
      chk("rst_flags", {rdata_valid, wdata_req, busy, done}, 4'b0000);
      n_reset = 1'b1;

      // 1: single-word write, mode 0, div 4
      wlist = '{8'h3C, 8'h00, 8'h00, 8'h00};
      mlist = '{8'h96, 8'h00, 8'h00, 8'h00};
      run_frame(1'b0, 1'b0, 1'b0, 10'd4, 1'b1, 8'hA5, 4'd0, 0, 0);
      chk("t1_mosi", cap[23:0], 24'h64A53C);
      chk("t1_nlead", nlead, 24);
      chk("t1_ss_act", ss_act, 2'b01);
      chk("t1_hp_min", hp_min, 5);
      chk("t1_hp_max", hp_max, 5);
      chk("t1_done", ndone, 1);
      chk("t1_req", nreq, 0);
      chk("t1_nvalid", nvalid, 1);
      chk("t1_rdata", rd[0], 8'h96);
      chk("t1_end", {sck_end, ss_end, busy_end}, 4'b0110);
      // start during GAP must be dropped
      @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      cnt_busy = 0;
      repeat (12) begin
         @(negedge clock);
         if (busy) cnt_busy++;
      end
      chk("t1_gap_start_dropped", cnt_busy, 0);

      // 2: read burst, mode 3
      wlist = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
      mlist = '{8'h11, 8'h22, 8'h33, 8'h00};
      run_frame(1'b1, 1'b1, 1'b1, 10'd2, 1'b0, 8'h0F, 4'd2, 0, 0);
      chk("t2_mosi", cap[39:0], 40'h650F000000);
      chk("t2_nlead", nlead, 40);
      chk("t2_ss_act", ss_act, 2'b10);
      chk("t2_nvalid", nvalid, 3);
      chk("t2_rd0", rd[0], 8'h11);
      chk("t2_rd1", rd[1], 8'h22);
      chk("t2_rd2", rd[2], 8'h33);
      chk("t2_sck_end", sck_end, 1'b1);
      wait_gap(4);
      chk("t2_sck_idle_after", sck, 1'b1);

      // 3: four-word write burst fed on wdata_req
      wlist = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
      mlist = '{8'h00, 8'h00, 8'h00, 8'h00};
      run_frame(1'b0, 1'b0, 1'b0, 10'd1, 1'b0, 8'h3C, 4'd3, 0, 0);
      chk("t3_mosi", cap[47:0], 48'h643CA1B2C3D4);
      chk("t3_nlead", nlead, 48);
      chk("t3_req", nreq, 3);
      chk("t3_done", ndone, 1);
      wait_gap(3);

      // 5: start mid-frame ignored, then reset at bit 10
      wlist = '{8'h77, 8'h88, 8'h00, 8'h00};
      run_frame(1'b0, 1'b0, 1'b0, 10'd2, 1'b0, 8'h5A, 4'd1, 3, 10);
      chk("t5_aborted", aborted, 1'b1);
      chk("t5_first10", cap[9:0], 10'h191);
      chk("t5_ss_kept", ss_n, 2'b10);
      chk("t5_sck_kept", sck, 1'b1);
      n_reset = 1'b0;
      #1;
      chk("t5_rst_ss_n", ss_n, 2'b11);
      chk("t5_rst_sck_busy", {sck, busy, done, mosi}, 4'b0000);
      @(negedge clock);
      n_reset = 1'b1;
      cnt_done = 0; cnt_busy = 0;
      repeat (20) begin
         @(negedge clock);
         if (done) cnt_done++;
         if (busy) cnt_busy++;
      end
      chk("t5_no_done", cnt_done, 0);
      chk("t5_no_busy", cnt_busy, 0);

      // 4: divider extremes
      wlist = '{8'h7E, 8'h00, 8'h00, 8'h00};
      run_frame(1'b0, 1'b0, 1'b0, 10'd0, 1'b1, 8'h81, 4'd0, 0, 0);
      chk("t4a_hp", {hp_min[15:0], hp_max[15:0]}, {16'd1, 16'd1});
      chk("t4a_nlead", nlead, 24);
      chk("t4a_mosi", cap[23:0], 24'h64817E);
      chk("t4a_done", ndone, 1);
      wait_gap(2);
      run_frame(1'b0, 1'b0, 1'b0, 10'd1023, 1'b1, 8'h81, 4'd0, 0, 0);
      chk("t4b_hp", {hp_min[15:0], hp_max[15:0]}, {16'd1024, 16'd1024});
      chk("t4b_nlead", nlead, 24);
      chk("t4b_done", ndone, 1);
      wait_gap(1026);

`ifdef SPI_LOOPBACK_EN
      // 6: loopback returns the written words, selects stay high
      wlist = '{8'h5A, 8'hC3, 8'h00, 8'h00};
      mlist = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
      loopback = 1'b1;
      run_frame(1'b0, 1'b0, 1'b0, 10'd1, 1'b0, 8'h11, 4'd1, 0, 0);
      chk("t6_nvalid", nvalid, 2);
      chk("t6_rd0", rd[0], 8'h5A);
      chk("t6_rd1", rd[1], 8'hC3);
      chk("t6_ss_act", ss_act, 2'b11);
      wait_gap(3);
      loopback = 1'b0;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
